// File: rtl/athos_obi_bridge_pkg.sv
// Shared types and helpers for the ATHOS OBI-to-register bridge and its response FIFO.
package athos_obi_bridge_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        ERR  = 2'd2
    } bridge_state_e;

    // Pointer width that stays legal for a single-entry FIFO.
    function automatic int unsigned ptr_width(input int unsigned depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/athos_resp_fifo.sv
// Synchronous response FIFO; push and pop may coincide, including when full.
module athos_resp_fifo
    import athos_obi_bridge_pkg::*;
#(
    parameter int unsigned Depth = 2,
    parameter int unsigned Width = 33
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic                       push,
    input  logic [Width-1:0]           din,
    input  logic                       pop,
    output logic [Width-1:0]           dout,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(Depth+1)-1:0] count
);

    localparam int unsigned PtrW = ptr_width(Depth);
    localparam int unsigned CntW = $clog2(Depth + 1);

    logic [Width-1:0] mem [Depth];
    logic [PtrW-1:0]  wr_ptr;
    logic [PtrW-1:0]  rd_ptr;
    logic             do_push;
    logic             do_pop;

    function automatic logic [PtrW-1:0] next_ptr(input logic [PtrW-1:0] p);
        return (p == PtrW'(Depth - 1)) ? '0 : p + 1'b1;
    endfunction

    assign empty   = (count == '0);
    assign full    = (count == CntW'(Depth));
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | pop);
    assign dout    = mem[rd_ptr];

    always_ff @(posedge clk_i) begin
        if (do_push) begin
            mem[wr_ptr] <= din;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= next_ptr(wr_ptr);
            if (do_pop)  rd_ptr <= next_ptr(rd_ptr);
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/athos_obi_reg_bridge.sv
// OBI slave to register-bus bridge with in-order responses and up to Depth outstanding accesses.
// Define ATHOS_OBI_BRIDGE_ERR_EN to answer out-of-window addresses with an error instead of forwarding.
//   IDLE | holding register empty
//   REQ  | held access presented on the register bus
//   ERR  | held access is out of range, error response queued without a register access
module athos_obi_reg_bridge
    import athos_obi_bridge_pkg::*;
#(
    parameter int unsigned          AddrWidth  = 32,
    parameter int unsigned          DataWidth  = 32,
    parameter int unsigned          Depth      = 2,
    parameter logic [AddrWidth-1:0] BaseAddr   = '0,
    parameter logic [AddrWidth:0]   RangeBytes = (AddrWidth + 1)'(4096)
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic                       obi_req_i,
    output logic                       obi_gnt_o,
    input  logic [AddrWidth-1:0]       obi_addr_i,
    input  logic                       obi_we_i,
    input  logic [DataWidth/8-1:0]     obi_be_i,
    input  logic [DataWidth-1:0]       obi_wdata_i,
    output logic                       obi_rvalid_o,
    input  logic                       obi_rready_i,
    output logic [DataWidth-1:0]       obi_rdata_o,
    output logic                       obi_err_o,
    input  logic                       ip_ready_i,
    output logic                       reg_valid_o,
    input  logic                       reg_ready_i,
    output logic [AddrWidth-1:0]       reg_addr_o,
    output logic                       reg_write_o,
    output logic [DataWidth/8-1:0]     reg_wstrb_o,
    output logic [DataWidth-1:0]       reg_wdata_o,
    input  logic [DataWidth-1:0]       reg_rdata_i,
    input  logic                       reg_error_i,
    output logic [$clog2(Depth+1)-1:0] outstanding_o
);

    localparam int unsigned CntW = $clog2(Depth + 1);

    typedef struct packed {
        logic [DataWidth-1:0] rdata;
        logic                 err;
    } resp_t;

    bridge_state_e   state;
    logic            held;
    logic            hs;
    logic            drain;
    logic            take;
    logic            range_ok;
    resp_t           push_entry;
    resp_t           head;
    logic            fifo_pop;
    logic            fifo_full;
    logic            fifo_empty;
    logic [CntW-1:0] fifo_count;
    logic [CntW-1:0] occ;

`ifdef ATHOS_OBI_BRIDGE_ERR_EN
    logic [AddrWidth:0] addr_ext;
    logic [AddrWidth:0] win_lo;
    logic [AddrWidth:0] win_hi;

    assign addr_ext = {1'b0, obi_addr_i};
    assign win_lo   = {1'b0, BaseAddr};
    assign win_hi   = win_lo + RangeBytes;
    assign range_ok = (addr_ext >= win_lo) && (addr_ext < win_hi);
`else
    assign range_ok = 1'b1;
`endif

    // The holding register frees up either on a register handshake or when an error is queued.
    assign held  = (state != IDLE);
    assign hs    = reg_valid_o & reg_ready_i;
    assign drain = hs | (state == ERR);
    assign occ   = fifo_count + CntW'(held);

    assign obi_gnt_o = obi_req_i & ip_ready_i & (occ < CntW'(Depth)) & ~fifo_full
                     & (~held | drain);
    assign take      = obi_gnt_o;

    assign push_entry.rdata = ((state == ERR) || reg_write_o) ? '0 : reg_rdata_i;
    assign push_entry.err   = (state == ERR) | reg_error_i;
    assign fifo_pop         = ~fifo_empty & obi_rready_i;

    assign obi_rvalid_o  = ~fifo_empty;
    assign obi_rdata_o   = fifo_empty ? '0 : head.rdata;
    assign obi_err_o     = fifo_empty ? 1'b0 : head.err;
    assign outstanding_o = occ;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state       <= IDLE;
            reg_valid_o <= 1'b0;
            reg_addr_o  <= '0;
            reg_write_o <= 1'b0;
            reg_wstrb_o <= '0;
            reg_wdata_o <= '0;
        end else if (take) begin
            state       <= range_ok ? REQ : ERR;
            reg_valid_o <= range_ok;
            reg_addr_o  <= obi_addr_i;
            reg_write_o <= obi_we_i;
            reg_wstrb_o <= obi_be_i;
            reg_wdata_o <= obi_wdata_i;
        end else if (drain) begin
            state       <= IDLE;
            reg_valid_o <= 1'b0;
        end
    end

    athos_resp_fifo #(
        .Depth (Depth),
        .Width ($bits(resp_t))
    ) u_resp_fifo (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .push   (drain),
        .din    (push_entry),
        .pop    (fifo_pop),
        .dout   (head),
        .full   (fifo_full),
        .empty  (fifo_empty),
        .count  (fifo_count)
    );

endmodule

// File: tb/tb_athos_obi_reg_bridge.sv
// Bench for athos_obi_reg_bridge: directed scenarios plus random traffic against a queue-based model.
module tb_athos_obi_reg_bridge;

    localparam int DEPTH = 2;
    localparam longint BASE  = 0;
    localparam longint RANGE = 4096;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req, we, rready, ip_ready, reg_ready, reg_error;
    logic [31:0] addr, wdata, reg_rdata;
    logic [3:0]  be;
    logic        gnt, rvalid, err, reg_valid, reg_write;
    logic [31:0] rdata, reg_addr, reg_wdata;
    logic [3:0]  reg_wstrb;
    logic [1:0]  outstanding;

    always #5 clk = ~clk;

    athos_obi_reg_bridge #(.Depth(DEPTH)) dut (
        .clk_i(clk), .rst_ni(rst_n),
        .obi_req_i(req), .obi_gnt_o(gnt), .obi_addr_i(addr), .obi_we_i(we),
        .obi_be_i(be), .obi_wdata_i(wdata), .obi_rvalid_o(rvalid), .obi_rready_i(rready),
        .obi_rdata_o(rdata), .obi_err_o(err), .ip_ready_i(ip_ready),
        .reg_valid_o(reg_valid), .reg_ready_i(reg_ready), .reg_addr_o(reg_addr),
        .reg_write_o(reg_write), .reg_wstrb_o(reg_wstrb), .reg_wdata_o(reg_wdata),
        .reg_rdata_i(reg_rdata), .reg_error_i(reg_error), .outstanding_o(outstanding)
    );

    typedef struct {
        logic [31:0] addr;
        logic        we;
        logic [3:0]  be;
        logic [31:0] wdata;
        logic        ok;
    } txn_t;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
    } rsp_t;

    txn_t pend[$];
    rsp_t rsp_q[$];
    int total = 0;
    int bad = 0;
    int gnt_cnt = 0;
    int rsp_cnt = 0;
    logic        s_gnt, s_rvalid, s_reg_valid, s_err;
    logic [31:0] s_rdata;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic in_range(input logic [31:0] a);
`ifdef ATHOS_OBI_BRIDGE_ERR_EN
        return (longint'(a) >= BASE) && (longint'(a) < BASE + RANGE);
`else
        return 1'b1;
`endif
    endfunction

    // Called at posedge+1 with inputs already applied; checks, advances the model, returns at next posedge+1.
    task automatic step();
        txn_t t;
        rsp_t r;
        logic hs_m, err_m, exp_gnt, exp_rv, exp_rq;
        int   occ_m;
        #1;
        occ_m   = pend.size() + rsp_q.size();
        exp_rq  = (pend.size() > 0) && pend[0].ok;
        hs_m    = exp_rq && reg_ready;
        err_m   = (pend.size() > 0) && !pend[0].ok;
        exp_gnt = req && ip_ready && (occ_m < DEPTH) && ((pend.size() == 0) || hs_m || err_m);
        exp_rv  = rsp_q.size() > 0;
        chk("outstanding", outstanding, occ_m);
        chk("gnt", gnt, exp_gnt);
        chk("reg_valid", reg_valid, exp_rq);
        if (exp_rq) begin
            chk("reg_addr", reg_addr, pend[0].addr);
            chk("reg_write", reg_write, pend[0].we);
            chk("reg_wstrb", reg_wstrb, pend[0].be);
            chk("reg_wdata", reg_wdata, pend[0].wdata);
        end
        chk("rvalid", rvalid, exp_rv);
        if (exp_rv) begin
            chk("rdata", rdata, rsp_q[0].rdata);
            chk("err", err, rsp_q[0].err);
        end
        s_gnt = gnt; s_rvalid = rvalid; s_reg_valid = reg_valid; s_rdata = rdata; s_err = err;
        if (gnt) gnt_cnt++;
        if (rvalid && rready) rsp_cnt++;
        if (exp_rv && rready) void'(rsp_q.pop_front());
        if (hs_m) begin
            r.rdata = pend[0].we ? 32'h0 : reg_rdata;
            r.err   = reg_error;
            rsp_q.push_back(r);
        end
        if (err_m) begin
            r.rdata = 32'h0;
            r.err   = 1'b1;
            rsp_q.push_back(r);
        end
        if (hs_m || err_m) void'(pend.pop_front());
        if (exp_gnt) begin
            t.addr = addr; t.we = we; t.be = be; t.wdata = wdata; t.ok = in_range(addr);
            pend.push_back(t);
        end
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] rand_addr();
        case ($urandom_range(0, 3))
            0:       return 32'($urandom_range(0, 4095));
            1:       return 32'h0FF0 + 32'($urandom_range(0, 31));
            2:       return $urandom;
            default: return 32'($urandom_range(0, 8191));
        endcase
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        rst_n = 1'b0; req = 0; we = 0; rready = 0; ip_ready = 0; reg_ready = 0; reg_error = 0;
        addr = 0; wdata = 0; reg_rdata = 0; be = 0;
        #12;
        chk("rst_gnt", gnt, 0);
        chk("rst_rvalid", rvalid, 0);
        chk("rst_rdata", rdata, 0);
        chk("rst_err", err, 0);
        chk("rst_reg_valid", reg_valid, 0);
        chk("rst_reg_addr", reg_addr, 0);
        chk("rst_reg_write", reg_write, 0);
        chk("rst_reg_wstrb", reg_wstrb, 0);
        chk("rst_reg_wdata", reg_wdata, 0);
        chk("rst_outstanding", outstanding, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        // single read, minimum latency
        req = 1; addr = 32'h10; we = 0; be = 4'hF; ip_ready = 1; reg_ready = 1;
        reg_rdata = 32'hDEADBEEF; rready = 1;
        step();
        chk("rd_gnt_t0", s_gnt, 1);
        chk("rd_regvalid_t0", s_reg_valid, 0);
        req = 0;
        step();
        chk("rd_regvalid_t1", s_reg_valid, 1);
        chk("rd_rvalid_t1", s_rvalid, 0);
        step();
        chk("rd_rvalid_t2", s_rvalid, 1);
        chk("rd_rdata_t2", s_rdata, 32'hDEADBEEF);
        chk("rd_err_t2", s_err, 0);

        // write stalled by reg_ready
        req = 1; we = 1; be = 4'h3; addr = 32'h20; wdata = 32'h12345678; reg_ready = 0;
        step();
        req = 0;
        for (int i = 0; i < 4; i++) begin
            reg_ready = (i == 3);
            chk("wr_wstrb", reg_wstrb, 4'h3);
            chk("wr_addr", reg_addr, 32'h20);
            step();
            chk("wr_regvalid", s_reg_valid, 1);
        end
        step();
        chk("wr_rvalid", s_rvalid, 1);
        chk("wr_rdata", s_rdata, 0);
        step();
        chk("wr_single_rsp", s_rvalid, 0);

        // fill to Depth with rready stalled
        we = 0; be = 4'hF; rready = 0; reg_ready = 1; req = 1; gnt_cnt = 0; rsp_cnt = 0;
        for (int i = 0; i < 6; i++) begin
            addr = 32'h100 + 32'(4 * i); reg_rdata = $urandom;
            step();
        end
        chk("fill_grants", gnt_cnt, DEPTH);
        chk("fill_outstanding", outstanding, DEPTH);
        chk("fill_gnt_low", s_gnt, 0);
        rready = 1; n = 0;
        while (gnt_cnt < 4 && n < 40) begin
            addr = 32'h200 + 32'(4 * n); reg_rdata = $urandom;
            step();
            n++;
        end
        chk("fill_all_granted", gnt_cnt, 4);
        req = 0;
        for (int i = 0; i < 8; i++) step();
        chk("fill_rsp_count", rsp_cnt, 4);

        // just past the window
        req = 1; addr = 32'h1000; we = 0; reg_rdata = 32'hA5A5A5A5; reg_error = 0;
        step();
        req = 0;
        step();
`ifdef ATHOS_OBI_BRIDGE_ERR_EN
        chk("oor_regvalid", s_reg_valid, 0);
`else
        chk("oor_regvalid", s_reg_valid, 1);
`endif
        step();
        chk("oor_rvalid", s_rvalid, 1);
`ifdef ATHOS_OBI_BRIDGE_ERR_EN
        chk("oor_err", s_err, 1);
        chk("oor_rdata", s_rdata, 0);
`else
        chk("oor_err", s_err, 0);
        chk("oor_rdata", s_rdata, 32'hA5A5A5A5);
`endif

        // ip_ready gating
        ip_ready = 0; req = 1; addr = 32'h40;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("ipr_gnt_low", s_gnt, 0);
        end
        ip_ready = 1;
        step();
        chk("ipr_gnt_same_cycle", s_gnt, 1);
        req = 0;
        for (int i = 0; i < 4; i++) step();

        // reset while in REQ with one queued response
        rready = 0; reg_ready = 1; req = 1; addr = 32'h50;
        step();
        addr = 32'h54;
        step();
        req = 0; reg_ready = 0;
        chk("mid_pre_regvalid", reg_valid, 1);
        chk("mid_pre_outstanding", outstanding, 2);
        rst_n = 0;
        #1;
        chk("mid_regvalid", reg_valid, 0);
        chk("mid_rvalid", rvalid, 0);
        chk("mid_outstanding", outstanding, 0);
        pend.delete();
        rsp_q.delete();
        @(posedge clk); #1;
        chk("mid_regvalid_cyc", reg_valid, 0);
        chk("mid_outstanding_cyc", outstanding, 0);
        rst_n = 1;
        rready = 1;
        step();

        // random traffic
        for (int i = 0; i < 500; i++) begin
            req       = ($urandom_range(0, 9) < 7);
            ip_ready  = ($urandom_range(0, 9) < 8);
            reg_ready = ($urandom_range(0, 9) < 6);
            rready    = ($urandom_range(0, 9) < 6);
            reg_error = ($urandom_range(0, 9) == 0);
            addr      = rand_addr();
            we        = $urandom_range(0, 1);
            be        = 4'($urandom);
            wdata     = $urandom;
            reg_rdata = $urandom;
            step();
        end
        req = 0; reg_ready = 1; rready = 1; ip_ready = 1;
        for (int i = 0; i < 10; i++) step();
        chk("drain_outstanding", outstanding, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
